class_sum_argmax: RTL and testbench

- Downstream consumer of the clause-evaluation flop stage in the TsetlinKWS inference datapath.
- Takes the registered per-clause fire results as a stream of weighted votes, accumulates one signed saturating sum per keyword class, then runs a sequential argmax.
- Outputs the winning class index and its sum to the result interface through a valid/ready handshake.

---
 rtl/tkws_pkg.sv | 25 ++
 rtl/class_sum_sat_acc.sv | 40 ++++
 rtl/class_sum_argmax.sv | 129 ++++++++++++
 tb/tb_class_sum_argmax.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tkws_pkg.sv
// Shared types and helpers for the TsetlinKWS class-sum / argmax stage.
package tkws_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_e;

  localparam int N_CLASS_DEF  = 12;
  localparam int WEIGHT_W_DEF = 8;
  localparam int SUM_W_DEF    = 14;

  // Signed add clamped to the range of a sum_w-bit two's-complement value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int sum_w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (sum_w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (sum_w - 1));
    if (s > hi)      sat_add = hi[31:0];
    else if (s < lo) sat_add = lo[31:0];
    else             sat_add = s[31:0];
  endfunction

endpackage

// File: rtl/class_sum_sat_acc.sv
// Per-class signed saturating sum register file: one write port (accumulate)
// and one combinational read port driven from the registers.
module class_sum_sat_acc
  import tkws_pkg::*;
#(
  parameter int N_CLASS  = N_CLASS_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int SUM_W    = SUM_W_DEF,
  localparam int CLASS_W = $clog2(N_CLASS)
) (
  input  logic                CP,
  input  logic                CDN,
  input  logic                clr_i,
  input  logic                wr_en_i,
  input  logic [CLASS_W-1:0]  wr_idx_i,
  input  logic [WEIGHT_W-1:0] wr_weight_i,
  input  logic [CLASS_W-1:0]  rd_idx_i,
  output logic [SUM_W-1:0]    rd_sum_o
);

  logic [SUM_W-1:0]   sum_q [N_CLASS];
  logic signed [31:0] add_res;

  always_comb begin
    add_res = sat_add(32'($signed(sum_q[wr_idx_i])), 32'($signed(wr_weight_i)), SUM_W);
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      for (int i = 0; i < N_CLASS; i++) sum_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < N_CLASS; i++) sum_q[i] <= '0;
    end else if (wr_en_i) begin
      sum_q[wr_idx_i] <= add_res[SUM_W-1:0];
    end
  end

  assign rd_sum_o = sum_q[rd_idx_i];

endmodule

// File: rtl/class_sum_argmax.sv
// Accumulates weighted clause votes per keyword class, then scans the sums
// one class per cycle and presents the argmax over a valid/ready handshake.
module class_sum_argmax
  import tkws_pkg::*;
#(
  parameter int N_CLASS  = N_CLASS_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int SUM_W    = SUM_W_DEF,
  localparam int CLASS_W = $clog2(N_CLASS)
) (
  input  logic                CP,
  input  logic                CDN,
  input  logic                start_i,
  input  logic                vote_valid_i,
  output logic                vote_ready_o,
  input  logic [CLASS_W-1:0]  vote_class_i,
  input  logic [WEIGHT_W-1:0] vote_weight_i,
  input  logic                vote_fire_i,
  input  logic                vote_last_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [CLASS_W-1:0]  result_class_o,
  output logic [SUM_W-1:0]    result_sum_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [CLASS_W:0]   N_CLASS_C = (CLASS_W+1)'(N_CLASS);
  localparam logic [CLASS_W-1:0] LAST_IDX  = CLASS_W'(N_CLASS - 1);

  state_e                    state_q;
  logic [CLASS_W-1:0]        scan_idx_q;
  logic signed [SUM_W-1:0]   best_sum_q;
  logic [CLASS_W-1:0]        best_idx_q;
  logic                      vote_ready_q;
  logic                      result_valid_q;
  logic                      busy_q;
  logic                      err_q;

  logic                      transfer;
  logic                      in_range;
  logic                      wr_en;
  logic [SUM_W-1:0]          rd_sum;

  always_comb begin
    transfer = vote_valid_i && vote_ready_q;
    in_range = {1'b0, vote_class_i} < N_CLASS_C;
    wr_en    = transfer && vote_fire_i && in_range && !start_i;
  end

  class_sum_sat_acc #(
    .N_CLASS  (N_CLASS),
    .WEIGHT_W (WEIGHT_W),
    .SUM_W    (SUM_W)
  ) u_acc (
    .CP          (CP),
    .CDN         (CDN),
    .clr_i       (start_i),
    .wr_en_i     (wr_en),
    .wr_idx_i    (vote_class_i),
    .wr_weight_i (vote_weight_i),
    .rd_idx_i    (scan_idx_q),
    .rd_sum_o    (rd_sum)
  );

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q        <= IDLE;
      scan_idx_q     <= '0;
      best_sum_q     <= '0;
      best_idx_q     <= '0;
      vote_ready_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else if (start_i) begin
      // Abort from any state; a vote presented alongside start is dropped.
      state_q        <= ACCUM;
      scan_idx_q     <= '0;
      vote_ready_q   <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b1;
      err_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ACCUM: begin
          if (transfer) begin
            if (!in_range) err_q <= 1'b1;
            if (vote_last_i) begin
              state_q      <= SCAN;
              vote_ready_q <= 1'b0;
              scan_idx_q   <= '0;
            end
          end
        end
        SCAN: begin
          // Strict greater-than keeps the lowest index on ties.
          if (scan_idx_q == '0 || $signed(rd_sum) > best_sum_q) begin
            best_sum_q <= $signed(rd_sum);
            best_idx_q <= scan_idx_q;
          end
          if (scan_idx_q == LAST_IDX) begin
            state_q        <= DONE;
            result_valid_q <= 1'b1;
          end else begin
            scan_idx_q <= scan_idx_q + CLASS_W'(1);
          end
        end
        DONE: begin
          if (result_ready_i) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vote_ready_o   = vote_ready_q;
  assign result_valid_o = result_valid_q;
  assign result_class_o = best_idx_q;
  assign result_sum_o   = best_sum_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_class_sum_argmax.sv
// Directed and randomized checks of class_sum_argmax against an integer model.
module tb_class_sum_argmax;

  localparam int N  = 12;
  localparam int CW = 4;
  localparam int WW = 8;
  localparam int SW = 14;
  localparam int SMAX = 8191;
  localparam int SMIN = -8192;

  logic          CP = 1'b0;
  logic          CDN = 1'b0;
  logic          start_i = 1'b0;
  logic          vote_valid_i = 1'b0;
  logic          vote_ready_o;
  logic [CW-1:0] vote_class_i = '0;
  logic [WW-1:0] vote_weight_i = '0;
  logic          vote_fire_i = 1'b0;
  logic          vote_last_i = 1'b0;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
  logic [CW-1:0] result_class_o;
  logic [SW-1:0] result_sum_o;
  logic          busy_o;
  logic          err_o;

  int n_assert = 0;
  int n_fail   = 0;
  int msum [N];
  bit merr;

  class_sum_argmax dut (
    .CP             (CP),
    .CDN            (CDN),
    .start_i        (start_i),
    .vote_valid_i   (vote_valid_i),
    .vote_ready_o   (vote_ready_o),
    .vote_class_i   (vote_class_i),
    .vote_weight_i  (vote_weight_i),
    .vote_fire_i    (vote_fire_i),
    .vote_last_i    (vote_last_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_class_o (result_class_o),
    .result_sum_o   (result_sum_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 CP = ~CP;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rsum();
    return int'($signed(result_sum_o));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) msum[i] = 0;
    merr = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge CP); #1;
    start_i = 1'b0;
    model_clear();
  endtask

  task automatic send_vote(input int cls, input int w, input bit fire, input bit last);
    vote_valid_i  = 1'b1;
    vote_class_i  = CW'(cls);
    vote_weight_i = WW'(w);
    vote_fire_i   = fire;
    vote_last_i   = last;
    @(posedge CP); #1;
    vote_valid_i = 1'b0;
    vote_last_i  = 1'b0;
    if (cls >= N) merr = 1'b1;
    else if (fire) begin
      msum[cls] = msum[cls] + w;
      if (msum[cls] > SMAX) msum[cls] = SMAX;
      if (msum[cls] < SMIN) msum[cls] = SMIN;
    end
  endtask

  // Call right after the last vote; checks latency, result, and handshake.
  task automatic finish_check(input string tag, input int hold);
    int cnt;
    int best;
    best = 0;
    for (int i = 1; i < N; i++) if (msum[i] > msum[best]) best = i;
    cnt = 1;
    while (!result_valid_o && cnt < 40) begin
      @(posedge CP); #1;
      cnt++;
    end
    check({tag, "_latency"}, cnt, 13);
    check({tag, "_class"}, int'(result_class_o), best);
    check({tag, "_sum"}, rsum(), msum[best]);
    check({tag, "_err"}, int'(err_o), int'(merr));
    for (int k = 0; k < hold; k++) begin
      @(posedge CP); #1;
      check({tag, "_hold_valid"}, int'(result_valid_o), 1);
      check({tag, "_hold_class"}, int'(result_class_o), best);
      check({tag, "_hold_sum"}, rsum(), msum[best]);
    end
    result_ready_i = 1'b1;
    @(posedge CP); #1;
    result_ready_i = 1'b0;
    check({tag, "_valid_drop"}, int'(result_valid_o), 0);
    check({tag, "_idle"}, int'(busy_o), 0);
  endtask

  initial begin
    logic [7:0] wb;
    int nb;
    model_clear();
    #12;
    check("rst_valid", int'(result_valid_o), 0);
    check("rst_ready", int'(vote_ready_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_class", int'(result_class_o), 0);
    check("rst_sum", rsum(), 0);
    @(negedge CP) CDN = 1'b1;
    @(posedge CP); #1;

    // Basic argmax
    do_start();
    check("basic_busy", int'(busy_o), 1);
    check("basic_ready", int'(vote_ready_o), 1);
    send_vote(3, 5, 1, 0);
    send_vote(7, 9, 1, 0);
    send_vote(3, 6, 1, 1);
    check("basic_exp_class", msum[3], 11);
    finish_check("basic", 0);

    // Tie resolves to lowest index; non-firing beat adds nothing
    do_start();
    send_vote(2, 4, 1, 0);
    send_vote(5, 4, 1, 0);
    send_vote(9, 20, 0, 1);
    finish_check("tie", 0);

    // Positive saturation
    do_start();
    for (int k = 0; k < 100; k++) send_vote(1, 127, 1, k == 99);
    finish_check("sat_pos", 0);

    // Negative saturation: every class driven to the floor, class 0 wins the tie
    do_start();
    for (int k = 0; k < 200; k++) send_vote(0, -128, 1, 0);
    for (int c = 1; c < N; c++)
      for (int k = 0; k < 65; k++) send_vote(c, -128, 1, (c == N-1) && (k == 64));
    finish_check("sat_neg", 0);

    // All-negative sums
    do_start();
    for (int c = 0; c < N; c++) send_vote(c, -3, 1, 0);
    send_vote(6, 1, 1, 1);
    finish_check("allneg", 0);

    // Randomized inferences
    for (int r = 0; r < 3; r++) begin
      do_start();
      nb = int'($urandom_range(20, 60));
      for (int k = 0; k < nb; k++) begin
        wb = 8'($urandom);
        send_vote(int'($urandom_range(0, N-1)), int'($signed(wb)),
                  bit'($urandom_range(0, 1)), k == nb-1);
      end
      finish_check("rand", 0);
    end

    // Out-of-range class, then abort during SCAN
    do_start();
    send_vote(4, 10, 1, 0);
    send_vote(13, 5, 1, 0);
    check("err_set", int'(err_o), 1);
    send_vote(0, 1, 1, 1);
    repeat (3) @(posedge CP);
    #1;
    // Simultaneous vote with start must be discarded
    vote_valid_i  = 1'b1;
    vote_class_i  = CW'(8);
    vote_weight_i = WW'(50);
    vote_fire_i   = 1'b1;
    do_start();
    vote_valid_i = 1'b0;
    check("abort_err", int'(err_o), 0);
    check("abort_busy", int'(busy_o), 1);
    check("abort_ready", int'(vote_ready_o), 1);
    check("abort_valid", int'(result_valid_o), 0);
    send_vote(10, 2, 1, 0);
    send_vote(8, 1, 1, 1);
    finish_check("abort_fresh", 0);

    // Backpressure in DONE
    do_start();
    send_vote(11, 33, 1, 0);
    send_vote(4, -7, 1, 1);
    finish_check("bp", 10);

    // Reset mid-ACCUM
    do_start();
    send_vote(14, 3, 1, 0);
    send_vote(2, 3, 1, 0);
    check("mid_err_pre", int'(err_o), 1);
    #3;
    CDN = 1'b0;
    #1;
    check("mid_rst_ready", int'(vote_ready_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_err", int'(err_o), 0);
    check("mid_rst_valid", int'(result_valid_o), 0);
    check("mid_rst_class", int'(result_class_o), 0);
    check("mid_rst_sum", rsum(), 0);
    @(negedge CP) CDN = 1'b1;
    repeat (2) @(posedge CP);
    #1;
    check("post_rst_idle", int'(busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
